// File: rtl/int_dispatch_seq.sv
// Interrupt-dispatch microsequencer: idle M-cycle, SP decrement, push PCH, push PCL,
// then load PC from the resolved vector. Advances only on MSTEP-qualified CLK edges.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | no dispatch; normal opcode fetch allowed
// S_M1   | idle M-cycle, IME cleared on entry
// S_M2   | SP decrement
// S_M3   | SP decrement, PCH written to [SP]; winner resolved on exit
// S_M4   | PCL written to [SP]
// S_M5   | PC loaded from vector (PCH = 0x00, PCL = {BRO, 3'b000})
module int_dispatch_seq #(
    parameter int          NUM_INT = 5,
    parameter logic [1:0]  VEC_HI  = 2'b01
) (
    input  logic               CLK,
    input  logic               nRES,
    input  logic               MSTEP,
    input  logic               BOUNDARY,
    input  logic               HALT,
    input  logic               IME,
    input  logic [NUM_INT-1:0] IE,
    input  logic [NUM_INT-1:0] IF,
    output logic               DISPATCH,
    output logic               WAKE,
    output logic               IME_CLR,
    output logic [NUM_INT-1:0] IF_CLR,
    output logic               SP_DEC,
    output logic               PCH_TO_DB,
    output logic               PCL_TO_DB,
    output logic               MEM_WR,
    output logic               LOAD_PC,
    output logic [4:0]         BRO
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M1   = 3'd1,
        S_M2   = 3'd2,
        S_M3   = 3'd3,
        S_M4   = 3'd4,
        S_M5   = 3'd5
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [NUM_INT-1:0]   pend;
    logic                 any;
    logic [2:0]           win_idx;
    logic [NUM_INT-1:0]   win_onehot;
    logic [4:0]           vec_q;
    logic                 wake_done;
    logic                 enter_m1;
    logic                 resolve;

    assign pend = IE & IF;
    assign any  = |pend;

    // Scan from the top so the lowest set index is the last one written and wins.
    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (pend[i]) begin
                win_idx       = 3'(i);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        DISPATCH  = 1'b0;
        SP_DEC    = 1'b0;
        PCH_TO_DB = 1'b0;
        PCL_TO_DB = 1'b0;
        MEM_WR    = 1'b0;
        LOAD_PC   = 1'b0;
        BRO       = 5'b00000;
        case (state)
            S_IDLE: begin
                if (MSTEP && IME && any && (BOUNDARY || HALT)) begin
                    state_nx = S_M1;
                end
            end
            S_M1: begin
                DISPATCH = 1'b1;
                if (MSTEP) state_nx = S_M2;
            end
            S_M2: begin
                DISPATCH = 1'b1;
                SP_DEC   = 1'b1;
                if (MSTEP) state_nx = S_M3;
            end
            S_M3: begin
                DISPATCH  = 1'b1;
                SP_DEC    = 1'b1;
                PCH_TO_DB = 1'b1;
                MEM_WR    = 1'b1;
                if (MSTEP) state_nx = S_M4;
            end
            S_M4: begin
                DISPATCH  = 1'b1;
                PCL_TO_DB = 1'b1;
                MEM_WR    = 1'b1;
                if (MSTEP) state_nx = S_M5;
            end
            S_M5: begin
                DISPATCH = 1'b1;
                LOAD_PC  = 1'b1;
                BRO      = vec_q;
                // Back-to-back dispatch skips IDLE so DISPATCH never drops.
                if (MSTEP) begin
                    state_nx = (BOUNDARY && IME && any) ? S_M1 : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign enter_m1 = (state_nx == S_M1) && (state != S_M1);
    assign resolve  = (state == S_M3) && MSTEP;

    // Late resolution lets the PCH push (which may hit IE) cancel or redirect the vector.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            IME_CLR   <= 1'b0;
            IF_CLR    <= '0;
            vec_q     <= '0;
            WAKE      <= 1'b0;
            wake_done <= 1'b0;
        end else begin
            IME_CLR <= enter_m1;
            IF_CLR  <= '0;
            if (resolve) begin
                if (any) begin
                    vec_q  <= {VEC_HI, win_idx};
                    IF_CLR <= win_onehot;
                end else begin
                    vec_q  <= '0;
                end
            end
            WAKE <= HALT && any && !wake_done;
            if (!HALT) begin
                wake_done <= 1'b0;
            end else if (any) begin
                wake_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_int_dispatch_seq.sv
// Directed bench for int_dispatch_seq: walks each dispatch scenario M-cycle by M-cycle
// and compares strobes, vectors and pulse counts against hand-computed values.
module tb_int_dispatch_seq;

    logic       clk_sys;
    logic       rst_b;
    logic       mstep;
    logic       boundary;
    logic       halt;
    logic       ime;
    logic [4:0] ie;
    logic [4:0] if_reg;
    logic       dispatch;
    logic       wake;
    logic       ime_clr;
    logic [4:0] if_clr;
    logic       sp_dec;
    logic       pch_to_db;
    logic       pcl_to_db;
    logic       mem_wr;
    logic       load_pc;
    logic [4:0] bro;

    int n_vec;
    int n_err;
    int wake_cnt;
    int ime_clr_cnt;
    int if_clr_cnt;
    int disp_cnt;
    int snap_a;
    int snap_b;
    int snap_c;

    // {DISPATCH, SP_DEC, PCH_TO_DB, PCL_TO_DB, MEM_WR, LOAD_PC}
    logic [5:0]  strobes;
    logic [17:0] all_outs;
    assign strobes  = {dispatch, sp_dec, pch_to_db, pcl_to_db, mem_wr, load_pc};
    assign all_outs = {dispatch, wake, ime_clr, if_clr, sp_dec, pch_to_db,
                       pcl_to_db, mem_wr, load_pc, bro};

    int_dispatch_seq #(.NUM_INT(5), .VEC_HI(2'b01)) dut (
        .CLK       (clk_sys),
        .nRES      (rst_b),
        .MSTEP     (mstep),
        .BOUNDARY  (boundary),
        .HALT      (halt),
        .IME       (ime),
        .IE        (ie),
        .IF        (if_reg),
        .DISPATCH  (dispatch),
        .WAKE      (wake),
        .IME_CLR   (ime_clr),
        .IF_CLR    (if_clr),
        .SP_DEC    (sp_dec),
        .PCH_TO_DB (pch_to_db),
        .PCL_TO_DB (pcl_to_db),
        .MEM_WR    (mem_wr),
        .LOAD_PC   (load_pc),
        .BRO       (bro)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (wake)     wake_cnt++;
        if (ime_clr)  ime_clr_cnt++;
        if (|if_clr)  if_clr_cnt++;
        if (dispatch) disp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Three quiet clocks then one MSTEP clock; returns just after the negedge following
    // the MSTEP edge, so one-CLK pulses launched by that edge are still visible.
    task automatic step_m();
        repeat (3) @(negedge clk_sys);
        mstep = 1'b1;
        @(negedge clk_sys);
        mstep = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        wake_cnt = 0; ime_clr_cnt = 0; if_clr_cnt = 0; disp_cnt = 0;
        rst_b = 1'b0; mstep = 1'b0; boundary = 1'b0; halt = 1'b0; ime = 1'b0;
        ie = 5'h00; if_reg = 5'h00;

        repeat (3) @(negedge clk_sys);
        #1;
        chk("reset_outs", 32'(all_outs), 32'h0);
        rst_b = 1'b1;
        repeat (2) @(negedge clk_sys);
        #1;

        // Single request, source 2 -> vector 0x50
        ime = 1'b1; ie = 5'h1F; if_reg = 5'h04; boundary = 1'b1;
        repeat (2) @(negedge clk_sys);
        #1;
        chk("single_no_mstep", 32'(dispatch), 32'h0);
        snap_a = ime_clr_cnt; snap_b = if_clr_cnt; snap_c = disp_cnt;
        step_m();
        chk("single_m1", 32'(strobes), 32'h20);
        chk("single_imeclr", 32'(ime_clr), 32'h1);
        step_m();
        chk("single_m2", 32'(strobes), 32'h30);
        step_m();
        chk("single_m3", 32'(strobes), 32'h3A);
        chk("single_bro_m3", 32'(bro), 32'h0);
        step_m();
        chk("single_m4", 32'(strobes), 32'h26);
        chk("single_ifclr", 32'(if_clr), 32'h04);
        if_reg = 5'h00;
        step_m();
        chk("single_m5", 32'(strobes), 32'h21);
        chk("single_bro", 32'(bro), 32'h0A);
        step_m();
        chk("single_idle", 32'(strobes), 32'h00);
        chk("single_bro_idle", 32'(bro), 32'h0);
        chk("single_disp_len", 32'(disp_cnt - snap_c), 32'd20);
        chk("single_imeclr_cnt", 32'(ime_clr_cnt - snap_a), 32'd1);
        chk("single_ifclr_cnt", 32'(if_clr_cnt - snap_b), 32'd1);

        // Priority: sources 1, 3, 4 pending -> 1 then 3 back to back
        if_reg = 5'h1A;
        step_m();
        step_m();
        step_m();
        step_m();
        chk("prio_ifclr", 32'(if_clr), 32'h02);
        if_reg = 5'h18;
        step_m();
        chk("prio_bro", 32'(bro), 32'h09);
        step_m();
        chk("prio_rearm_m1", 32'(strobes), 32'h20);
        chk("prio_rearm_imeclr", 32'(ime_clr), 32'h1);
        step_m();
        step_m();
        step_m();
        chk("prio2_ifclr", 32'(if_clr), 32'h08);
        if_reg = 5'h10;
        step_m();
        chk("prio2_bro", 32'(bro), 32'h0B);
        ime = 1'b0;
        step_m();
        chk("prio_idle", 32'(dispatch), 32'h0);
        if_reg = 5'h00;

        // Cancel: IE dropped during M3
        ime = 1'b1; ie = 5'h01; if_reg = 5'h01;
        snap_a = ime_clr_cnt; snap_b = if_clr_cnt;
        step_m();
        step_m();
        step_m();
        ie = 5'h00;
        step_m();
        chk("cancel_ifclr", 32'(if_clr), 32'h00);
        step_m();
        chk("cancel_m5", 32'(strobes), 32'h21);
        chk("cancel_bro", 32'(bro), 32'h00);
        step_m();
        chk("cancel_idle", 32'(dispatch), 32'h0);
        chk("cancel_imeclr_cnt", 32'(ime_clr_cnt - snap_a), 32'd1);
        chk("cancel_ifclr_cnt", 32'(if_clr_cnt - snap_b), 32'd0);
        if_reg = 5'h00;

        // Redirect: IE moves from source 0 to source 1 during M3
        ie = 5'h01; if_reg = 5'h03;
        step_m();
        step_m();
        step_m();
        ie = 5'h02;
        step_m();
        chk("redir_ifclr", 32'(if_clr), 32'h02);
        if_reg = 5'h01;
        step_m();
        chk("redir_bro", 32'(bro), 32'h09);
        step_m();
        chk("redir_idle", 32'(dispatch), 32'h0);
        if_reg = 5'h00;

        // HALT with IME=0: wake only, once
        boundary = 1'b0; ime = 1'b0;
        snap_a = wake_cnt;
        halt = 1'b1; ie = 5'h10; if_reg = 5'h10;
        step_m();
        step_m();
        chk("halt_wake_cnt", 32'(wake_cnt - snap_a), 32'd1);
        chk("halt_no_disp", 32'(dispatch), 32'h0);
        halt = 1'b0;
        step_m();
        snap_a = wake_cnt;
        halt = 1'b1; ime = 1'b1;
        step_m();
        chk("halt2_wake_cnt", 32'(wake_cnt - snap_a), 32'd1);
        chk("halt2_m1", 32'(strobes), 32'h20);
        step_m();
        step_m();
        step_m();
        chk("halt2_ifclr", 32'(if_clr), 32'h10);
        if_reg = 5'h00; halt = 1'b0;
        step_m();
        chk("halt2_bro", 32'(bro), 32'h0C);
        ime = 1'b0;
        step_m();
        chk("halt2_idle", 32'(dispatch), 32'h0);

        // Reset during M4
        ime = 1'b1; boundary = 1'b1; ie = 5'h1F; if_reg = 5'h04;
        step_m();
        step_m();
        step_m();
        step_m();
        chk("rst_pre_m4", 32'(strobes), 32'h26);
        rst_b = 1'b0;
        #1;
        chk("rst_async_strobes", 32'(strobes), 32'h00);
        chk("rst_async_all", 32'(all_outs), 32'h0);
        @(negedge clk_sys);
        rst_b = 1'b1;
        repeat (4) @(negedge clk_sys);
        #1;
        chk("rst_stays_idle", 32'(dispatch), 32'h0);
        step_m();
        chk("rst_restart_m1", 32'(strobes), 32'h20);
        chk("rst_restart_imeclr", 32'(ime_clr), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
